// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: access size codes,
// FSM state encoding, default geometry and small helper functions.
// Latency: n/a (definitions only). Backpressure: n/a.
package dmem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Default memory window: word 0 lives at byte address 1000.
  localparam int DMEM_BASE_ADDR_DEF = 1000;
  localparam int DMEM_DEPTH_DEF     = 2250;

  // Natural alignment: halves need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Saturating increment used by the optional statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the CPU load/store path and dmem_ctrl.
// Latency: n/a (wires only). Backpressure: req_valid/req_ready and rsp_valid/rsp_ready.
// master = CPU side (drives req_*, rsp_ready); slave = memory side.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Lane steering: store byte-enables/replicated data, load lane select + extension.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_size/i_addr_lo/i_signed select the access; i_wdata -> o_be/o_wdata,
//        i_rword (raw memory word) -> o_rdata (aligned, extended load result).
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian: byte k sits in bits [8k+7:8k]; addr[1] picks the half.
  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        // Replicating into every lane lets the byte-enable alone place the data.
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data memory: one outstanding load/store, RD_LATENCY cycles to response.
// Latency: rsp_valid rises RD_LATENCY edges after the accept edge (1..8).
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: clk, rst (async active-high), bus (dmem_ctrl_if.slave request/response).
// Optional: define DMEM_STATS_EN to add stat_loads/stat_stores/stat_errs outputs.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = DMEM_DEPTH_DEF,
  parameter int BASE_ADDR  = DMEM_BASE_ADDR_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // Storage: deliberately not reset.
  logic [31:0] r_mem [DEPTH];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;
  logic             r_we;
  logic [31:0]      r_rdata;

  logic              w_accept;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_widx;
  logic [IDX_W-1:0]  w_idx;
  logic              w_below;
  logic              w_above;
  logic              w_bad_size;
  logic              w_misal;
  logic              w_err;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_al;
  logic [31:0]       w_ld_data;

  // ---------------------------------------------------------------------
  // Address decode and error checks
  // ---------------------------------------------------------------------
  assign w_off      = bus.req_addr - BASE_A;
  assign w_widx     = w_off >> 2;
  assign w_below    = bus.req_addr < BASE_A;
  // Addresses below the base wrap to huge offsets and also trip this check.
  assign w_above    = w_widx >= DEPTH_A;
  assign w_bad_size = (bus.req_size == SZ_ILLEGAL);
  assign w_misal    = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign w_err      = w_bad_size | w_misal | w_below | w_above;
  // Only meaningful when !w_err; an in-window index always fits IDX_W bits.
  assign w_idx      = w_widx[IDX_W-1:0];
  assign w_rword    = r_mem[w_idx];

  assign bus.req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;

  dmem_lane_fmt u_lane_fmt (
    .i_size    (bus.req_size),
    .i_addr_lo (bus.req_addr[1:0]),
    .i_signed  (bus.req_signed),
    .i_wdata   (bus.req_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_al),
    .o_rdata   (w_ld_data)
  );

  // ---------------------------------------------------------------------
  // Storage write: committed on the accept edge, masked to addressed lanes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (RD_LATENCY <= 1) begin
            w_state_nxt = ST_RESP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end
      ST_BUSY: begin
        // The edge that decrements the counter to zero is also the edge that
        // enters RESP, giving exactly RD_LATENCY edges from accept to valid.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Response capture: the load result is formatted at accept time and held,
  // so only the outcome of the request (not its fields) needs registering.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_rdata <= 32'h0;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_we    <= bus.req_we;
      r_rdata <= (w_err || bus.req_we) ? 32'h0 : w_ld_data;
    end
  end

  // Outputs are forced to zero outside RESP so nothing leaks during BUSY.
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? r_rdata : 32'h0;
  assign bus.rsp_err   = bus.rsp_valid & r_err;

`ifdef DMEM_STATS_EN
  // ---------------------------------------------------------------------
  // Statistics: counted on the response handshake; errors count only once.
  // ---------------------------------------------------------------------
  logic        w_rsp_hs;
  logic [31:0] r_stat_loads;
  logic [31:0] r_stat_stores;
  logic [31:0] r_stat_errs;

  assign w_rsp_hs = (r_state == ST_RESP) && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_loads  <= 32'h0;
      r_stat_stores <= 32'h0;
      r_stat_errs   <= 32'h0;
    end else if (w_rsp_hs) begin
      if (r_err) begin
        r_stat_errs <= sat_inc(r_stat_errs);
      end else if (r_we) begin
        r_stat_stores <= sat_inc(r_stat_stores);
      end else begin
        r_stat_loads <= sat_inc(r_stat_loads);
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: dut0 runs with RD_LATENCY=4, dut1 with RD_LATENCY=1.
// Drivers push expected responses; per-DUT monitors pop and compare on rsp_valid rise.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int L0    = 4;
  localparam int L1    = 1;
  localparam int DEPTH = 2250;
  localparam int BASE  = 1000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  exp_t q0[$];
  exp_t q1[$];

  dmem_ctrl_if #(.ADDR_W(32)) if0 ();
  dmem_ctrl_if #(.ADDR_W(32)) if1 ();

`ifdef DMEM_STATS_EN
  logic [31:0] s0_loads, s0_stores, s0_errs;
  logic [31:0] s1_loads, s1_stores, s1_errs;
`endif

  dmem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(L0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
`ifdef DMEM_STATS_EN
    , .stat_loads(s0_loads), .stat_stores(s0_stores), .stat_errs(s0_errs)
`endif
  );

  dmem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(L1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
`ifdef DMEM_STATS_EN
    , .stat_loads(s1_loads), .stat_stores(s1_stores), .stat_errs(s1_errs)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void note_fail(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  // Monitors: compare each response once, on the negedge where rsp_valid rises.
  logic seen0 = 1'b0;
  logic seen1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if0.rsp_valid && !seen0) begin
      seen0 = 1'b1;
      if (q0.size() == 0) begin
        note_fail("dut0_unexpected_rsp");
      end else begin
        e = q0.pop_front();
        chk("dut0_rdata", if0.rsp_rdata, e.rdata);
        chk("dut0_err", {31'b0, if0.rsp_err}, {31'b0, e.err});
        chk("dut0_latency", 32'(cyc), 32'(e.due));
      end
    end else if (!if0.rsp_valid) begin
      seen0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.rsp_valid && !seen1) begin
      seen1 = 1'b1;
      if (q1.size() == 0) begin
        note_fail("dut1_unexpected_rsp");
      end else begin
        e = q1.pop_front();
        chk("dut1_rdata", if1.rsp_rdata, e.rdata);
        chk("dut1_err", {31'b0, if1.rsp_err}, {31'b0, e.err});
        chk("dut1_latency", 32'(cyc), 32'(e.due));
      end
    end else if (!if1.rsp_valid) begin
      seen1 = 1'b0;
    end
  end

  task automatic drive_req(input int d, input logic v, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_size = sz;
      if0.req_signed = sg; if0.req_addr = addr; if0.req_wdata = wd;
    end else begin
      if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
      if1.req_signed = sg; if1.req_addr = addr; if1.req_wdata = wd;
    end
  endtask

  // Issue one request, push its expected response, return just after the accept edge.
  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    int   t;
    exp_t e;
    @(negedge clk);
    drive_req(d, 1'b1, we, sz, sg, addr, wd);
    t = 0;
    while (((d == 0) ? !if0.req_ready : !if1.req_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      note_fail("accept_timeout");
    end else begin
      e.rdata = er;
      e.err   = ee;
      e.due   = cyc + ((d == 0) ? L0 : L1);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      @(posedge clk);
    end
    #1;
    drive_req(d, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (((d == 0) ? (q0.size() != 0 || if0.rsp_valid) : (q1.size() != 0 || if1.rsp_valid))
           && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) note_fail("drain_timeout");
  endtask

  task automatic wait_valid0();
    int t;
    t = 0;
    while (!if0.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) note_fail("wait_rsp_valid_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    exp_t e;
    rst = 1'b1;
    drive_req(0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_req_ready", {31'b0, if0.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, if0.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", if0.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, if0.rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'b0, if0.req_ready}, 32'd1);

    // Basic word store/load
    issue(0, 1, SZ_WORD, 0, 1000, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, SZ_WORD, 0, 1000, 32'h0, 32'hDEADBEEF, 0);

    // Byte/half lanes with sign/zero extension
    issue(0, 1, SZ_WORD, 0, 1004, 32'h0, 32'h0, 0);
    issue(0, 1, SZ_BYTE, 0, 1005, 32'hAAAAAA80, 32'h0, 0);
    issue(0, 0, SZ_BYTE, 1, 1005, 32'h0, 32'hFFFFFF80, 0);
    issue(0, 0, SZ_BYTE, 0, 1005, 32'h0, 32'h00000080, 0);
    issue(0, 0, SZ_WORD, 0, 1004, 32'h0, 32'h00008000, 0);
    issue(0, 0, SZ_BYTE, 1, 1003, 32'h0, 32'hFFFFFFDE, 0);
    issue(0, 0, SZ_HALF, 0, 1002, 32'h0, 32'h0000DEAD, 0);
    issue(0, 0, SZ_HALF, 1, 1000, 32'h0, 32'hFFFFBEEF, 0);
    issue(0, 1, SZ_HALF, 0, 1006, 32'h12347FFF, 32'h0, 0);
    issue(0, 0, SZ_HALF, 1, 1006, 32'h0, 32'h00007FFF, 0);
    issue(0, 0, SZ_WORD, 0, 1004, 32'h0, 32'h7FFF8000, 0);

    // Errors: misaligned, below/above window, illegal size; stores must not write
    issue(0, 0, SZ_HALF, 0, 1001, 32'h0, 32'h0, 1);
    issue(0, 0, SZ_WORD, 0, 1002, 32'h0, 32'h0, 1);
    issue(0, 0, SZ_WORD, 0, 996, 32'h0, 32'h0, 1);
    issue(0, 0, SZ_BYTE, 0, 999, 32'h0, 32'h0, 1);
    issue(0, 0, SZ_WORD, 0, BASE + 4 * DEPTH, 32'h0, 32'h0, 1);
    issue(0, 0, SZ_ILLEGAL, 0, 1000, 32'h0, 32'h0, 1);
    issue(0, 1, SZ_WORD, 0, 1002, 32'hFFFFFFFF, 32'h0, 1);
    issue(0, 1, SZ_ILLEGAL, 0, 1000, 32'h0, 32'h0, 1);
    issue(0, 0, SZ_WORD, 0, 1000, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 0, SZ_WORD, 0, 1004, 32'h0, 32'h7FFF8000, 0);

    // Last in-window word
    issue(0, 1, SZ_WORD, 0, BASE + 4 * (DEPTH - 1), 32'h0BADF00D, 32'h0, 0);
    issue(0, 0, SZ_WORD, 0, BASE + 4 * (DEPTH - 1), 32'h0, 32'h0BADF00D, 0);

    // Response backpressure: held stable, pending request not accepted
    drain(0);
    if0.rsp_ready = 1'b0;
    issue(0, 0, SZ_WORD, 0, 1000, 32'h0, 32'hDEADBEEF, 0);
    wait_valid0();
    drive_req(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 1004, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", {31'b0, if0.rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", if0.rsp_rdata, 32'hDEADBEEF);
      chk("hold_req_ready", {31'b0, if0.req_ready}, 32'd0);
      @(negedge clk);
    end
    if0.rsp_ready = 1'b1;
    e.rdata = 32'h7FFF8000;
    e.err   = 1'b0;
    e.due   = cyc + 1 + L0;
    q0.push_back(e);
    @(negedge clk);
    chk("release_req_ready", {31'b0, if0.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    drain(0);

    // Reset during BUSY: store stays committed, nothing responds afterwards
    issue(0, 1, SZ_WORD, 0, 1008, 32'h11223344, 32'h0, 0);
    issue(0, 1, SZ_WORD, 0, 1012, 32'h55667788, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    chk("busy_rst_req_ready", {31'b0, if0.req_ready}, 32'd0);
    chk("busy_rst_rsp_valid", {31'b0, if0.rsp_valid}, 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if0.rsp_valid) bad = 1'b1;
    end
    chk("no_rsp_after_busy_rst", {31'b0, bad}, 32'd0);
    chk("busy_rst_idle_ready", {31'b0, if0.req_ready}, 32'd1);

    // Reset while holding a response: outputs clear without a clock edge
    if0.rsp_ready = 1'b0;
    issue(0, 0, SZ_WORD, 0, 1008, 32'h0, 32'h11223344, 0);
    wait_valid0();
    #1 rst = 1'b1;
    #1;
    chk("resp_rst_rsp_valid", {31'b0, if0.rsp_valid}, 32'd0);
    chk("resp_rst_rsp_rdata", if0.rsp_rdata, 32'd0);
    chk("resp_rst_rsp_err", {31'b0, if0.rsp_err}, 32'd0);
    chk("resp_rst_req_ready", {31'b0, if0.req_ready}, 32'd0);
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    issue(0, 0, SZ_WORD, 0, 1012, 32'h0, 32'h55667788, 0);
    issue(0, 0, SZ_WORD, 0, 1008, 32'h0, 32'h11223344, 0);
    drain(0);

    // Single-cycle latency instance: 2 stores, 3 loads, 1 misaligned load
    issue(1, 1, SZ_WORD, 0, 1000, 32'hCAFEF00D, 32'h0, 0);
    issue(1, 1, SZ_HALF, 0, 1006, 32'h00001234, 32'h0, 0);
    issue(1, 0, SZ_WORD, 0, 1000, 32'h0, 32'hCAFEF00D, 0);
    issue(1, 0, SZ_BYTE, 0, 1002, 32'h0, 32'h000000FE, 0);
    issue(1, 0, SZ_HALF, 0, 1006, 32'h0, 32'h00001234, 0);
    issue(1, 0, SZ_WORD, 0, 1001, 32'h0, 32'h0, 1);
    drain(1);

`ifdef DMEM_STATS_EN
    chk("stat_loads", s1_loads, 32'd3);
    chk("stat_stores", s1_stores, 32'd2);
    chk("stat_errs", s1_errs, 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data-memory block; next generation of the CPU's combinational word-only data memory.
- Adds valid/ready request and response channels, configurable read latency, byte/halfword/word access with sign/zero extension, alignment and address-window error reporting.
- Sits between the CPU's ALU-address/store-data path and the load write-back mux; the CPU stalls on req_ready/rsp_valid.

Parameters:
- ADDR_W, 32, request address width.
- DEPTH, 2250, number of 32-bit words stored.
- BASE_ADDR, 1000, byte address of word 0; must be 4-aligned.
- RD_LATENCY, 1, cycles from request accept to rsp_valid; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bits used for byte/half.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-window or illegal size.

Behaviour:
- FSM states: IDLE, BUSY, RESP.
  - req_ready = 1 only in IDLE.
  - Accept occurs on an edge where req_valid && req_ready. It captures all req_* fields and moves to BUSY with latency counter = RD_LATENCY-1.
  - If RD_LATENCY = 1, accept goes straight to RESP.
- BUSY: the counter decrements each cycle; at 0 the FSM moves to RESP.
  - rsp_valid rises exactly RD_LATENCY edges after the accept edge.
- RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until an edge with rsp_ready = 1, then the FSM returns to IDLE.
  - No back-to-back overlap: at most one transaction is outstanding, so the next accept is earliest at the edge after the response handshake.
- Error checks (evaluated at accept):
  - req_size = 11.
  - half with addr[0] set.
  - word with addr[1:0] nonzero.
  - addr < BASE_ADDR.
  - (addr - BASE_ADDR) >> 2 >= DEPTH.
  - Any error: no memory write, rsp_err = 1, rsp_rdata = 0.
- Word index = (addr - BASE_ADDR) >> 2. Little-endian lanes: byte k = addr[1:0] selects bits [8k+7:8k]; half uses lanes {addr[1],0} and {addr[1],1}.
- Store: the memory write, masked to the addressed lanes, is committed on the accept edge. The response has rsp_err as computed and rsp_rdata = 0.
- Load: the word is read on the accept edge, then lane-selected and extended per req_signed. A load immediately following a store to the same word returns the stored data.
- Reset (asynchronous, any state, including mid-BUSY/RESP):
  - FSM goes to IDLE.
  - req_ready = 1 after reset deasserts, but 0 while rst is high.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
  - Memory array contents are not reset.
  - An in-flight transaction is dropped; a store accepted before reset stays committed.

Optional Feature:
- DMEM_STATS_EN.
  - Defined: adds outputs stat_loads, stat_stores and stat_errs, each 32 bits. They count completed response handshakes by type; an error counts in stat_errs only. Counters reset to 0 and saturate at all-ones.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings ST_IDLE, ST_BUSY, ST_RESP;
  - the default BASE_ADDR constant.
- One sub-module, dmem_lane_fmt (combinational): store byte-enable/data alignment and load lane-select/extend.
- The FSM, error checks and storage array live in dmem_ctrl.

Test Plan:
- Reset then store word 0xDEADBEEF to 1000, load word 1000 -> rsp_valid exactly RD_LATENCY cycles after accept, rdata 0xDEADBEEF, err 0.
- Store byte 0x80 to 1005, then load byte signed from 1005 -> 0xFFFFFF80. Load byte unsigned -> 0x00000080. Load word 1004 -> bits[15:8] = 0x80.
- Load half from 1001, load word from 1002, load word from 996, load word from 1000+4*DEPTH, req_size 11 -> each rsp_err 1, rdata 0; memory unchanged (reread 1000 intact).
- Hold rsp_ready low for 5 cycles in RESP -> rsp_valid and data stable, req_ready 0 and a pending req_valid not accepted; release -> next request accepted on the following edge.
- RD_LATENCY = 4, assert rst during BUSY -> outputs 0 immediately (asynchronously), FSM in IDLE, no rsp_valid afterwards; a subsequent load returns the pre-reset stored value.
- With DMEM_STATS_EN: 3 loads, 2 stores and 1 misaligned load -> stat_loads 3, stat_stores 2, stat_errs 1.
